// File: rtl/serializer_pkg.sv
// serializer_pkg: shared definitions for tuple_serializer.
//   state_t            : serializer FSM state encoding (IDLE, SHIFT)
//   in_w(size)         : width of the value field
//   lane_w(k)          : width of the lane field (0 when k == 1)
//   out_w(k, size)     : width of one {value, lane} slot
//   idx_w(k)           : width of the lane index register (never below 1)
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int in_w(input int size);
    return $clog2(size);
  endfunction

  function automatic int lane_w(input int k);
    return $clog2(k);
  endfunction

  function automatic int out_w(input int k, input int size);
    return in_w(size) + lane_w(k);
  endfunction

  function automatic int idx_w(input int k);
    return (lane_w(k) < 1) ? 1 : lane_w(k);
  endfunction

endpackage

// File: rtl/lane_select.sv
// lane_select: priority finder returning the lowest set bit of mask that lies
// above base (or at base when inclusive is set).
// Ports:
//   mask      : K-bit lane mask
//   base      : search start index
//   inclusive : 1 = base itself is a candidate, 0 = strictly above base
//   found     : a qualifying bit exists
//   sel       : index of the lowest qualifying bit (0 when none)
module lane_select #(
  parameter int K     = 4,
  parameter int IDX_W = 2
) (
  input  logic [K-1:0]     mask,
  input  logic [IDX_W-1:0] base,
  input  logic             inclusive,
  output logic             found,
  output logic [IDX_W-1:0] sel
);

  // Scan from the top down so the lowest qualifying bit is written last.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = K - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(base)) || (inclusive && (i == int'(base))))) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tuple_serializer.sv
// tuple_serializer: accepts a packed vector of K {value, lane} slots and
// emits them one slot per beat over a valid/ready stream.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   in_data    : K packed slots, slot i at [OUT_W*(i+1)-1 : OUT_W*i]
//   in_valid   : in_data valid
//   in_ready   : vector accepted when in_valid & in_ready
//   out_data   : current slot
//   out_valid  : out_data valid
//   out_ready  : beat consumed when out_valid & out_ready
//   out_last   : final beat of the current vector
//   in_mask    : (SERIALIZER_SKIP_EN only) lanes to emit, captured with in_data
// Build option SERIALIZER_SKIP_EN: skip lanes whose mask bit is 0; an all-zero
// mask is accepted and produces no beats.
module tuple_serializer
  import serializer_pkg::*;
#(
  parameter int K    = 4,
  parameter int SIZE = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [out_w(K,SIZE)*K-1:0]  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [out_w(K,SIZE)-1:0]    out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last
`ifdef SERIALIZER_SKIP_EN
  ,
  input  logic [K-1:0]                in_mask
`endif
);

  localparam int OUT_W = out_w(K, SIZE);
  localparam int IDX_W = idx_w(K);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(K - 1);

  state_t                  state_q, state_d;
  logic [K-1:0][OUT_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        first_idx, next_idx;
  logic                    first_found, last_beat, load;

`ifdef SERIALIZER_SKIP_EN
  logic [K-1:0] mask_q, mask_d;
  logic         next_found;

  lane_select #(.K(K), .IDX_W(IDX_W)) u_first (
    .mask      (in_mask),
    .base      ({IDX_W{1'b0}}),
    .inclusive (1'b1),
    .found     (first_found),
    .sel       (first_idx)
  );

  lane_select #(.K(K), .IDX_W(IDX_W)) u_next (
    .mask      (mask_q),
    .base      (idx_q),
    .inclusive (1'b0),
    .found     (next_found),
    .sel       (next_idx)
  );

  // No enabled lane above the current one means this beat closes the vector.
  assign last_beat = !next_found;
`else
  assign first_found = 1'b1;
  assign first_idx   = '0;
  assign next_idx    = idx_q + IDX_W'(1);
  assign last_beat   = (idx_q == LAST_LANE);
`endif

  assign out_valid = (state_q == SHIFT);
  assign out_data  = out_valid ? buf_q[idx_q] : '0;
  assign out_last  = out_valid & last_beat;
  // Ready also while the final beat leaves, so a waiting vector loads with no bubble.
  assign in_ready  = (state_q == IDLE) | (out_valid & out_ready & last_beat);
  assign load      = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
`ifdef SERIALIZER_SKIP_EN
    mask_d  = mask_q;
`endif
    if (load) begin
      buf_d   = in_data;
      idx_d   = first_idx;
      state_d = first_found ? SHIFT : IDLE;
`ifdef SERIALIZER_SKIP_EN
      mask_d  = in_mask;
`endif
    end else if (out_valid && out_ready) begin
      if (last_beat) state_d = IDLE;
      else           idx_d   = next_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
`ifdef SERIALIZER_SKIP_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
`ifdef SERIALIZER_SKIP_EN
      mask_q  <= mask_d;
`endif
    end
  end

endmodule
